// File: rtl/uart_rx_unit.sv
// UART receiver with built-in baud divider: start/data/parity/stop framing, mid-bit sampling.
// Optional macro UART_RX_SYNC_EN adds a 2-FF synchronizer on rx ahead of edge detection.
module uart_rx_unit #(
    parameter int CLK_FREQ_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       clk_mode,
    input  logic [2:0] baud_sel,
    input  logic       data_size,
    input  logic       parity_en,
    input  logic [1:0] parity_mode,
    output logic [7:0] data,
    output logic       valid,
    output logic       ready,
    output logic       new_data,
    output logic       uart_clk,
    output logic       uart_en
);

    localparam int CW = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Rounded bit period for table index {clk_mode, baud_sel}.
    function automatic logic [CW-1:0] calc_div(input int idx);
        logic [63:0] base;
        logic [63:0] num;
        base = (idx >= 8) ? 64'd460_800 : 64'd76_800;
        num  = 64'(CLK_FREQ_HZ) << (idx % 8);
        return CW'((num + (base >> 1)) / base);
    endfunction

    logic [CW-1:0] div_table [16];

    for (genvar gi = 0; gi < 16; gi++) begin : g_div
        assign div_table[gi] = calc_div(gi);
    end

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

    assign rx_s = sync_reg[1];
`else
    assign rx_s = rx;
`endif

    state_t        state_reg;
    logic          rx_prev_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] n_reg;
    logic [CW-1:0] h_reg;
    logic          dsize_reg;
    logic          pen_reg;
    logic [1:0]    pmode_reg;
    logic [7:0]    shift_reg;
    logic [2:0]    bit_idx_reg;
    logic          parity_ok_reg;
    logic [7:0]    data_reg;
    logic          valid_reg;
    logic          ready_reg;
    logic          new_data_reg;
    logic          uart_clk_reg;
    logic          uart_en_reg;

    logic          tick;
    logic          parity_exp;
    logic [2:0]    last_idx;

    assign tick     = uart_en_reg && (cnt_reg == h_reg - 1'b1);
    assign last_idx = dsize_reg ? 3'd7 : 3'd6;

    always_comb begin
        parity_exp = 1'b0;
        case (pmode_reg)
            2'b11:   parity_exp = ~^shift_reg;
            2'b10:   parity_exp = ^shift_reg;
            2'b01:   parity_exp = 1'b1;
            default: parity_exp = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            rx_prev_reg   <= 1'b1;
            cnt_reg       <= '0;
            n_reg         <= '0;
            h_reg         <= '0;
            dsize_reg     <= 1'b0;
            pen_reg       <= 1'b0;
            pmode_reg     <= 2'b00;
            shift_reg     <= 8'h00;
            bit_idx_reg   <= 3'd0;
            parity_ok_reg <= 1'b1;
            data_reg      <= 8'h00;
            valid_reg     <= 1'b0;
            ready_reg     <= 1'b1;
            new_data_reg  <= 1'b0;
            uart_clk_reg  <= 1'b0;
            uart_en_reg   <= 1'b0;
        end else begin
            rx_prev_reg  <= rx_s;
            new_data_reg <= 1'b0;

            // Free-running phase counter; uart_clk is high from each tick to the period wrap.
            if (uart_en_reg) begin
                if (cnt_reg == n_reg - 1'b1) begin
                    cnt_reg      <= '0;
                    uart_clk_reg <= 1'b0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
                if (tick) begin
                    uart_clk_reg <= 1'b1;
                end
            end else begin
                uart_clk_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (rx_prev_reg && !rx_s) begin
                        state_reg     <= ST_START;
                        ready_reg     <= 1'b0;
                        uart_en_reg   <= 1'b1;
                        cnt_reg       <= '0;
                        uart_clk_reg  <= 1'b0;
                        n_reg         <= div_table[{clk_mode, baud_sel}];
                        h_reg         <= div_table[{clk_mode, baud_sel}] >> 1;
                        dsize_reg     <= data_size;
                        pen_reg       <= parity_en;
                        pmode_reg     <= parity_mode;
                        shift_reg     <= 8'h00;
                        bit_idx_reg   <= 3'd0;
                        parity_ok_reg <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (rx_s) begin
                            state_reg   <= ST_IDLE;
                            ready_reg   <= 1'b1;
                            uart_en_reg <= 1'b0;
                        end else begin
                            state_reg <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift_reg[bit_idx_reg] <= rx_s;
                        bit_idx_reg            <= bit_idx_reg + 1'b1;
                        if (bit_idx_reg == last_idx) begin
                            state_reg <= pen_reg ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        parity_ok_reg <= (rx_s == parity_exp);
                        state_reg     <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Frame completes at the stop-bit sample; the remainder of the stop bit is ignored.
                    if (tick) begin
                        data_reg     <= shift_reg;
                        valid_reg    <= parity_ok_reg & rx_s;
                        new_data_reg <= 1'b1;
                        uart_en_reg  <= 1'b0;
                        ready_reg    <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    ready_reg   <= 1'b1;
                    uart_en_reg <= 1'b0;
                end
            endcase
        end
    end

    assign data     = data_reg;
    assign valid    = valid_reg;
    assign ready    = ready_reg;
    assign new_data = new_data_reg;
    assign uart_clk = uart_clk_reg;
    assign uart_en  = uart_en_reg;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Self-checking bench for uart_rx_unit at 100 MHz, 460800 baud (217 cycles per bit).
module tb_uart_rx_unit;

    localparam int BIT = 217;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       clk_mode;
    logic [2:0] baud_sel;
    logic       data_size;
    logic       parity_en;
    logic [1:0] parity_mode;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       new_data;
    logic       uart_clk;
    logic       uart_en;

    int checks   = 0;
    int failures = 0;
    int nd_count = 0;

    uart_rx_unit #(.CLK_FREQ_HZ(100_000_000)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .clk_mode   (clk_mode),
        .baud_sel   (baud_sel),
        .data_size  (data_size),
        .parity_en  (parity_en),
        .parity_mode(parity_mode),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .new_data   (new_data),
        .uart_clk   (uart_clk),
        .uart_en    (uart_en)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (new_data) nd_count++;
    end

    typedef struct {
        logic       dsize;
        logic       pen;
        logic [1:0] pmode;
        logic [7:0] tx;
        logic       par;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic dsize, input logic pen, input logic [7:0] b,
                        input logic par, input logic stop);
        hold(1'b0, BIT);
        for (int i = 0; i < (dsize ? 8 : 7); i++) hold(b[i], BIT);
        if (pen) hold(par, BIT);
        hold(stop, BIT);
        hold(1'b1, 20);
    endtask

    initial begin
        int nd_before;

        vecs[0] = '{1'b1, 1'b1, 2'b01, 8'h95, 1'b1, 1'b1, 8'h95, 1'b1}; // mark ok
        vecs[1] = '{1'b1, 1'b1, 2'b10, 8'h95, 1'b1, 1'b1, 8'h95, 1'b0}; // even, bad parity
        vecs[2] = '{1'b0, 1'b0, 2'b00, 8'h2A, 1'b0, 1'b1, 8'h2A, 1'b1}; // 7-bit, no parity
        vecs[3] = '{1'b1, 1'b0, 2'b00, 8'h55, 1'b0, 1'b0, 8'h55, 1'b0}; // framing error
        vecs[4] = '{1'b1, 1'b1, 2'b11, 8'h95, 1'b1, 1'b1, 8'h95, 1'b1}; // odd ok
        vecs[5] = '{1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1}; // space ok
        vecs[6] = '{1'b0, 1'b1, 2'b10, 8'hFF, 1'b1, 1'b1, 8'h7F, 1'b1}; // 7-bit even, bit7 = 0
        vecs[7] = '{1'b1, 1'b1, 2'b10, 8'hA3, 1'b0, 1'b1, 8'hA3, 1'b1}; // even ok
        vecs[8] = '{1'b1, 1'b1, 2'b01, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0}; // mark, bad parity

        rst = 1'b1; rx = 1'b1; clk_mode = 1'b1; baud_sel = 3'd0;
        data_size = 1'b1; parity_en = 1'b0; parity_mode = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_ready", 32'(ready), 32'h1);
        check("rst_new_data", 32'(new_data), 32'h0);
        check("rst_uart_clk", 32'(uart_clk), 32'h0);
        check("rst_uart_en", 32'(uart_en), 32'h0);
        hold(1'b1, 10);

        for (int i = 0; i < 9; i++) begin
            data_size = vecs[i].dsize;
            parity_en = vecs[i].pen;
            parity_mode = vecs[i].pmode;
            nd_before = nd_count;
            send(vecs[i].dsize, vecs[i].pen, vecs[i].tx, vecs[i].par, vecs[i].stop);
            check($sformatf("v%0d_pulses", i), 32'(nd_count - nd_before), 32'd1);
            check($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_ready", i), 32'(ready), 32'h1);
            check($sformatf("v%0d_uart_en", i), 32'(uart_en), 32'h0);
        end

        // False start: 500 ns low pulse.
        nd_before = nd_count;
        hold(1'b0, 20);
        check("fs_ready_low", 32'(ready), 32'h0);
        check("fs_uart_en", 32'(uart_en), 32'h1);
        hold(1'b0, 30);
        hold(1'b1, 300);
        check("fs_pulses", 32'(nd_count - nd_before), 32'd0);
        check("fs_ready", 32'(ready), 32'h1);
        check("fs_data", 32'(data), 32'(vecs[8].exp_data));
        check("fs_valid", 32'(valid), 32'(vecs[8].exp_valid));

        // uart_clk phase, then reset in the middle of data bit 3.
        data_size = 1'b1; parity_en = 1'b0;
        nd_before = nd_count;
        hold(1'b0, 50);
        check("uclk_pre_tick", 32'(uart_clk), 32'h0);
        hold(1'b0, 60);
        check("uclk_tick0", 32'(uart_clk), 32'h1);
        hold(1'b0, 107);
        hold(1'b0, 13);
        check("uclk_low1", 32'(uart_clk), 32'h0);
        hold(1'b0, 100);
        check("uclk_tick1", 32'(uart_clk), 32'h1);
        hold(1'b0, 104);
        hold(1'b1, BIT);
        hold(1'b0, BIT);
        hold(1'b1, 100);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mr_ready", 32'(ready), 32'h1);
        check("mr_uart_en", 32'(uart_en), 32'h0);
        check("mr_uart_clk", 32'(uart_clk), 32'h0);
        check("mr_data", 32'(data), 32'h00);
        hold(1'b1, 300);
        check("mr_pulses", 32'(nd_count - nd_before), 32'd0);

        nd_before = nd_count;
        send(1'b1, 1'b0, 8'hA3, 1'b0, 1'b1);
        check("post_rst_pulses", 32'(nd_count - nd_before), 32'd1);
        check("post_rst_data", 32'(data), 32'hA3);
        check("post_rst_valid", 32'(valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
